// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the line memory responder: FSM encoding and default widths.
package line_mem_responder_pkg;

  // Byte offset of the line index inside a byte address (32-byte lines).
  localparam int LINE_OFFSET    = 5;
  localparam int DEFAULT_DATA_W = 256;
  localparam int DEFAULT_ADDR_W = 32;

  // Latency counter width; covers the legal latency range 1..255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/line_mem_array.sv
// Single-port line storage: synchronous write, synchronous read into a held read register.
module line_mem_array
  import line_mem_responder_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port.
  // NOTE: the storage array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read register: loads only on a read, so it holds across later writes and idle cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the data-cache line interface. Accepts one request at a time,
// latches it completely, and completes it after LATENCY cycles with a one-cycle ack.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_q, wr_d;

  logic               enter_ack;
  logic               cur_wr;
  logic [IDX_W-1:0]   cur_idx;
  logic [DATA_W-1:0]  cur_wdata;
  logic               mem_we, mem_re;

  // Line offset and the bits above the index field play no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[LINE_OFFSET-1:0], addr_i[ADDR_W-1:LINE_OFFSET+IDX_W]};

  // State, latency counter and latched request; reset drops any in-flight request.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Next state: accept in IDLE, count down in BUSY, single ACK cycle, then back to IDLE.
  // NOTE: every signal gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[LINE_OFFSET +: IDX_W];
          wdata_d = data_i;
          wr_d    = write_i;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ACK : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs and memory strobes: the array is accessed on the edge that enters ACK. With
  // LATENCY==1 that edge is the acceptance edge, so the request comes straight from the inputs.
  always_comb begin
    ack_o     = (state_q == ACK);
    enter_ack = (state_d == ACK) && (state_q != ACK);
    if (state_q == IDLE) begin
      cur_wr    = write_i;
      cur_idx   = addr_i[LINE_OFFSET +: IDX_W];
      cur_wdata = data_i;
    end else begin
      cur_wr    = wr_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
    end
    mem_we = enter_ack && cur_wr;
    mem_re = enter_ack && !cur_wr;
  end

  line_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder (LATENCY=10 and LATENCY=1 builds).
module tb_line_mem_responder;
  import line_mem_responder_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  logic         en0 = 1'b0, wr0 = 1'b0;
  logic [31:0]  addr0 = '0;
  logic [255:0] wdata0 = '0;
  logic         ack0;
  logic [255:0] rdata0;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] wdata1 = '0;
  logic         ack1;
  logic [255:0] rdata1;

  localparam logic [255:0] PAT_P  = {8{32'h0BAD_F00D}};
  localparam logic [255:0] PAT_Q  = {8{32'h5555_AAAA}};
  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_C  = {8{32'hC0DE_C0DE}};
  localparam logic [255:0] PAT_D  = {8{32'hDEAD_BEEF}};

  line_mem_responder #(.LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en0), .write_i(wr0), .addr_i(addr0),
    .data_i(wdata0), .ack_o(ack0), .data_o(rdata0)
  );

  line_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(wdata1), .ack_o(ack1), .data_o(rdata1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One request on the LATENCY=10 instance; returns latency (cycles from drive to sampled ack)
  // and data_o seen during ack. With toggle set, inputs change every BUSY cycle.
  task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                     input bit toggle, output int lat, output logic [255:0] rd);
    int start;
    bit seen;
    @(negedge clk);
    en0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d;
    start = cyc; seen = 1'b0; lat = -1; rd = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack0) begin
        seen = 1'b1; lat = cyc - start; rd = rdata0; en0 = 1'b0;
      end else if (toggle) begin
        wr0 = ~wr0; addr0 = addr0 ^ 32'h20; wdata0 = ~wdata0;
      end
    end
    if (!seen) check("req_timeout", 256'(seen), 256'(1));
  endtask

  initial begin
    int lat;
    logic [255:0] rd;
    int ack_cnt, first_ack, second_ack;
    bit double_ack, prev_ack;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", 256'(ack0), 256'(0));
    check("rst_data", rdata0, 256'(0));
    check("rst_state", 256'(dut.state_q), 256'(IDLE));
    rst = 1'b0;

    // Test 1: write completes normally, then a second write is killed by reset mid-BUSY.
    req(1'b1, 32'h0000_0080, PAT_P, 1'b0, lat, rd);
    check("t1_pre_lat", 256'(lat), 256'(10));
    @(negedge clk);
    en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0080; wdata0 = PAT_Q;
    repeat (4) @(negedge clk);
    rst = 1'b1; en0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      prev_ack = prev_ack | ack0;
    end
    check("t1_no_ack", 256'(prev_ack), 256'(0));
    check("t1_line_kept", dut.u_array.mem_q[4], PAT_P);
    check("t1_state", 256'(dut.state_q), 256'(IDLE));

    // Test 2: write then read the same line; both take exactly 10 cycles.
    req(1'b1, 32'h0000_0040, PAT_A5, 1'b0, lat, rd);
    check("t2_wr_lat", 256'(lat), 256'(10));
    req(1'b0, 32'h0000_0040, '0, 1'b0, lat, rd);
    check("t2_rd_lat", 256'(lat), 256'(10));
    check("t2_rd_data", rd, PAT_A5);

    // Test 3: aliasing through the ignored upper address bits; a write leaves data_o alone.
    req(1'b1, 32'h0000_4020, 256'h1234, 1'b0, lat, rd);
    check("t3_wr_keeps_data_o", rd, PAT_A5);
    req(1'b0, 32'h0000_0020, '0, 1'b0, lat, rd);
    check("t3_alias_data", rd, 256'h1234);
    check("t3_backdoor", dut.u_array.mem_q[1], 256'h1234);

    // Test 5: inputs toggled during BUSY do not disturb the latched read.
    req(1'b1, 32'h0000_0060, PAT_C, 1'b0, lat, rd);
    req(1'b0, 32'h0000_0040, '0, 1'b1, lat, rd);
    check("t5_lat", 256'(lat), 256'(10));
    check("t5_data", rd, PAT_A5);
    check("t5_line60_kept", dut.u_array.mem_q[3], PAT_C);
    check("t5_line40_kept", dut.u_array.mem_q[2], PAT_A5);

    // Enable dropped right after acceptance: the write still completes and acks.
    @(negedge clk);
    en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_00A0; wdata0 = PAT_D;
    @(negedge clk);
    en0 = 1'b0;
    lat = -1;
    for (int i = 2; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (ack0) lat = i;
    end
    check("t7_drop_lat", 256'(lat), 256'(10));
    check("t7_line_written", dut.u_array.mem_q[5], PAT_D);

    // Test 4: enable held high across acks; acks spaced LATENCY+1 apart, never back-to-back.
    @(negedge clk);
    en0 = 1'b1; wr0 = 1'b0; addr0 = 32'h0000_0020;
    ack_cnt = 0; first_ack = -1; second_ack = -1; double_ack = 1'b0; prev_ack = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (ack0) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = i;
        else if (second_ack < 0) second_ack = i;
        if (prev_ack) double_ack = 1'b1;
      end
      prev_ack = ack0;
    end
    en0 = 1'b0;
    check("t4_ack_count", 256'(ack_cnt), 256'(2));
    check("t4_first_lat", 256'(first_ack), 256'(10));
    check("t4_spacing", 256'(second_ack - first_ack), 256'(11));
    check("t4_no_double", 256'(double_ack), 256'(0));
    check("t4_data", rdata0, 256'h1234);
    repeat (2) @(negedge clk);
    check("t4_idle", 256'(dut.state_q), 256'(IDLE));

    // Test 6: LATENCY=1 build acks in the cycle right after acceptance.
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = 256'h77;
    @(negedge clk);
    check("t6_wr_ack", 256'(ack1), 256'(1));
    en1 = 1'b0;
    @(negedge clk);
    check("t6_wr_ack_low", 256'(ack1), 256'(0));
    check("t6_idle", 256'(dut1.state_q), 256'(IDLE));
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0040;
    @(negedge clk);
    check("t6_rd_ack", 256'(ack1), 256'(1));
    check("t6_rd_data", rdata1, 256'h77);
    en1 = 1'b0;
    @(negedge clk);
    check("t6_rd_ack_low", 256'(ack1), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
